// File: rtl/game_ctl.sv
// Game sequencer: screen state, bug placement, score and countdown timer (pclk domain).
module game_ctl #(
    parameter int unsigned H_MAX          = 800,
    parameter int unsigned V_MAX          = 600,
    parameter int unsigned BUG_W          = 64,
    parameter int unsigned BUG_H          = 64,
    parameter int unsigned START_X        = 336,
    parameter int unsigned START_Y        = 268,
    parameter int unsigned START_W        = 128,
    parameter int unsigned START_H        = 64,
    parameter int unsigned MOVE_FRAMES    = 60,
    parameter int unsigned FRAMES_PER_SEC = 60,
    parameter int unsigned GAME_SECONDS   = 30,
    parameter int unsigned HIT_FRAMES     = 8
) (
    input  logic        pclk,
    input  logic        rst_n,
    input  logic        vsync_in,
    input  logic        mouse_left,
    input  logic [11:0] xpos,
    input  logic [11:0] ypos,
    output logic [1:0]  screen_sel,
    output logic [11:0] x_bugpos,
    output logic [11:0] y_bugpos,
    output logic [7:0]  score,
    output logic [7:0]  time_left,
    output logic        game_over
);

    // Bug left/top edge must land in [0, RANGE) so the sprite stays on screen.
    localparam int unsigned RANGE_X = H_MAX - BUG_W;
    localparam int unsigned RANGE_Y = V_MAX - BUG_H;
    localparam int unsigned FC_W    = $clog2(FRAMES_PER_SEC + 1);
    localparam int unsigned MC_W    = $clog2(MOVE_FRAMES + 1);
    localparam int unsigned HC_W    = $clog2(HIT_FRAMES + 1);

    typedef enum logic [1:0] {
        S_START = 2'd0,
        S_PLAY  = 2'd1,
        S_HIT   = 2'd2,
        S_OVER  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              sync1_q, sync2_q, sync3_q;
    logic              vsync_q;
    logic [15:0]       lfsr_q, lfsr_d;
    logic [11:0]       x_bugpos_q, x_bugpos_d;
    logic [11:0]       y_bugpos_q, y_bugpos_d;
    logic [7:0]        score_q, score_d;
    logic [7:0]        time_left_q, time_left_d;
    logic              game_over_q, game_over_d;
    logic [FC_W-1:0]   frame_cnt_q, frame_cnt_d;
    logic [MC_W-1:0]   move_cnt_q, move_cnt_d;
    logic [HC_W-1:0]   hit_cnt_q, hit_cnt_d;

    logic              click_c;
    logic              frame_tick_c;
    logic [11:0]       cand_x_c;
    logic [11:0]       cand_y_c;
    logic              bug_hit_c;
    logic              start_hit_c;
    logic              sec_wrap_c;
    logic              expire_c;
    logic              move_wrap_c;

    // Event detection, random candidate position and pointer hit tests.
    always_comb begin
        click_c      = sync2_q & ~sync3_q;
        frame_tick_c = vsync_in & ~vsync_q;
        lfsr_d       = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

        cand_x_c = {2'b00, lfsr_q[9:0]};
        if (cand_x_c >= 12'(RANGE_X)) begin
            cand_x_c = cand_x_c - 12'(RANGE_X);
        end
        cand_y_c = {2'b00, lfsr_q[15:6]};
        if (cand_y_c >= 12'(RANGE_Y)) begin
            cand_y_c = cand_y_c - 12'(RANGE_Y);
        end

        bug_hit_c = (xpos >= x_bugpos_q) && (xpos <= x_bugpos_q + 12'(BUG_W - 1)) &&
                    (ypos >= y_bugpos_q) && (ypos <= y_bugpos_q + 12'(BUG_H - 1));
        start_hit_c = (xpos >= 12'(START_X)) && (xpos <= 12'(START_X + START_W - 1)) &&
                      (ypos >= 12'(START_Y)) && (ypos <= 12'(START_Y + START_H - 1));

        sec_wrap_c  = frame_tick_c && (frame_cnt_q == FC_W'(FRAMES_PER_SEC - 1));
        expire_c    = sec_wrap_c && (time_left_q == 8'd1);
        move_wrap_c = frame_tick_c && (move_cnt_q == MC_W'(MOVE_FRAMES - 1));
    end

    // Next-state and registered-output computation.
    always_comb begin
        state_d     = state_q;
        x_bugpos_d  = x_bugpos_q;
        y_bugpos_d  = y_bugpos_q;
        score_d     = score_q;
        time_left_d = time_left_q;
        frame_cnt_d = frame_cnt_q;
        move_cnt_d  = move_cnt_q;
        hit_cnt_d   = hit_cnt_q;
        game_over_d = 1'b0;

        // Countdown runs through both PLAY and the hit flash.
        if ((state_q == S_PLAY || state_q == S_HIT) && frame_tick_c) begin
            if (sec_wrap_c) begin
                frame_cnt_d = '0;
                time_left_d = time_left_q - 8'd1;
            end else begin
                frame_cnt_d = frame_cnt_q + FC_W'(1);
            end
        end

        case (state_q)
            S_START: begin
                x_bugpos_d = 12'(START_X);
                y_bugpos_d = 12'(START_Y);
                if (click_c && start_hit_c) begin
                    state_d     = S_PLAY;
                    score_d     = 8'd0;
                    time_left_d = 8'(GAME_SECONDS);
                    frame_cnt_d = '0;
                    move_cnt_d  = '0;
                    hit_cnt_d   = '0;
                    x_bugpos_d  = cand_x_c;
                    y_bugpos_d  = cand_y_c;
                end
            end
            S_PLAY: begin
                if (frame_tick_c) begin
                    move_cnt_d = move_wrap_c ? '0 : move_cnt_q + MC_W'(1);
                end
                // Expiry beats a hit, a hit beats the idle relocation.
                if (expire_c) begin
                    state_d = S_OVER;
                end else if (click_c && bug_hit_c) begin
                    state_d    = S_HIT;
                    score_d    = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
                    hit_cnt_d  = '0;
                    move_cnt_d = '0;
                end else if (move_wrap_c) begin
                    x_bugpos_d = cand_x_c;
                    y_bugpos_d = cand_y_c;
                end
            end
            S_HIT: begin
                if (expire_c) begin
                    state_d = S_OVER;
                end else if (frame_tick_c) begin
                    if (hit_cnt_q == HC_W'(HIT_FRAMES - 1)) begin
                        state_d    = S_PLAY;
                        hit_cnt_d  = '0;
                        move_cnt_d = '0;
                        x_bugpos_d = cand_x_c;
                        y_bugpos_d = cand_y_c;
                    end else begin
                        hit_cnt_d = hit_cnt_q + HC_W'(1);
                    end
                end
            end
            S_OVER: begin
                if (click_c) begin
                    state_d = S_START;
                end
            end
            default: state_d = S_START;
        endcase

        game_over_d = (state_d == S_OVER);
    end

    // State, synchronizer, LFSR and counter registers.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_START;
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            sync3_q     <= 1'b0;
            vsync_q     <= 1'b0;
            lfsr_q      <= 16'hACE1;
            x_bugpos_q  <= 12'd0;
            y_bugpos_q  <= 12'd0;
            score_q     <= 8'd0;
            time_left_q <= 8'(GAME_SECONDS);
            game_over_q <= 1'b0;
            frame_cnt_q <= '0;
            move_cnt_q  <= '0;
            hit_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            sync1_q     <= mouse_left;
            sync2_q     <= sync1_q;
            sync3_q     <= sync2_q;
            vsync_q     <= vsync_in;
            lfsr_q      <= lfsr_d;
            x_bugpos_q  <= x_bugpos_d;
            y_bugpos_q  <= y_bugpos_d;
            score_q     <= score_d;
            time_left_q <= time_left_d;
            game_over_q <= game_over_d;
            frame_cnt_q <= frame_cnt_d;
            move_cnt_q  <= move_cnt_d;
            hit_cnt_q   <= hit_cnt_d;
        end
    end

    assign screen_sel = state_q;
    assign x_bugpos   = x_bugpos_q;
    assign y_bugpos   = y_bugpos_q;
    assign score      = score_q;
    assign time_left  = time_left_q;
    assign game_over  = game_over_q;

endmodule
